// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl: single-issue req/ack controller for a 256K x 16 asynchronous SRAM.
// All SRAM pins are registered; read strobe and write pulse widths come from RD_CYC / WR_CYC.
// Optional build macro SRAM_ASYNC_CTRL_POSTWR_EN: posted writes (ack in the write setup cycle).
module sram_async_ctrl #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_CYC = 1,
    parameter int unsigned WR_CYC = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        be,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_a,
    inout  wire  [DATA_W-1:0] sram_io,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

`ifdef SRAM_ASYNC_CTRL_POSTWR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    localparam int unsigned MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_DONE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               oe_drv;
    logic [DATA_W-1:0]  wdata_q;

    // Data bus is driven only from the registered write data while oe_drv is set
    assign sram_io = oe_drv ? wdata_q : {DATA_W{1'bz}};

    // Transaction sequencer with registered SRAM pins and client outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            sram_a    <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            oe_drv    <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        sram_a    <= addr;
                        sram_lb_n <= ~be[0];
                        sram_ub_n <= ~be[1];
                        sram_ce_n <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        if (we) begin
                            wdata_q <= wdata;
                            oe_drv  <= 1'b1;
                            ack     <= POSTED;
                            state   <= S_WR_SETUP;
                        end else begin
                            sram_oe_n <= 1'b0;
                            state     <= S_RD;
                        end
                    end
                end

                S_RD: begin
                    if (cnt == CNT_W'(RD_CYC - 1)) begin
                        rdata     <= sram_io;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        ack       <= 1'b1;
                        state     <= S_RD_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Turnaround cycle: strobes already high, SRAM releases the bus
                S_RD_DONE: begin
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                S_WR_SETUP: begin
                    ack       <= 1'b0;
                    sram_we_n <= 1'b0;
                    state     <= S_WR_PULSE;
                end

                S_WR_PULSE: begin
                    if (cnt == CNT_W'(WR_CYC - 1)) begin
                        sram_we_n <= 1'b1;
                        ack       <= ~POSTED;
                        state     <= S_WR_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Data hold after WE_ rises, then release everything
                S_WR_HOLD: begin
                    ack       <= 1'b0;
                    sram_ce_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    oe_drv    <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_async_ctrl.sv
// tb_sram_async_ctrl: two controller instances (RD/WR cycles 1/1 and 3/2), each with a
// behavioural async SRAM; results are compared with a word-level memory model.
module tb_sram_async_ctrl;

    localparam int unsigned NI = 2;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;

`ifdef SRAM_ASYNC_CTRL_POSTWR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    typedef struct {
        int           lat;
        logic [15:0]  rd;
        int           acc_wait;
        int           we_low;
        int           oe_low;
        int           drv_cyc;
        int           ack_cyc;
        int           bad;
        int           conflict;
        bit           gap_ok;
        bit           tmo;
    } txn_res_t;

    logic                  CLK;
    logic                  RESET;
    logic [NI-1:0]         req;
    logic [NI-1:0]         we;
    logic [NI-1:0][AW-1:0] addr;
    logic [NI-1:0][DW-1:0] wdata;
    logic [NI-1:0][1:0]    be;

    wire  [NI-1:0]         ack;
    wire  [NI-1:0]         busy;
    wire  [NI-1:0][DW-1:0] rdata;
    wire  [NI-1:0][AW-1:0] sram_a;
    wire  [NI-1:0]         ce_n;
    wire  [NI-1:0]         oe_n;
    wire  [NI-1:0]         we_n;
    wire  [NI-1:0]         lb_n;
    wire  [NI-1:0]         ub_n;
    wire  [NI-1:0]         drv;

    int errors;
    int checks;

    logic [DW-1:0] ref_mem [int unsigned];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned RC = (g == 0) ? 1 : 3;
        localparam int unsigned WC = (g == 0) ? 1 : 2;
        wire  [DW-1:0] io;
        logic [DW-1:0] mem [0:(1<<AW)-1];

        sram_async_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_CYC(RC), .WR_CYC(WC)) u_dut (
            .CLK(CLK), .RESET(RESET), .req(req[g]), .we(we[g]), .addr(addr[g]),
            .wdata(wdata[g]), .be(be[g]), .ack(ack[g]), .rdata(rdata[g]), .busy(busy[g]),
            .sram_a(sram_a[g]), .sram_io(io), .sram_ce_n(ce_n[g]), .sram_oe_n(oe_n[g]),
            .sram_we_n(we_n[g]), .sram_lb_n(lb_n[g]), .sram_ub_n(ub_n[g])
        );

        assign drv[g] = u_dut.oe_drv;

        // Async SRAM: drives the bus during a read, latches lanes while WE_ is low
        assign io = (!ce_n[g] && !oe_n[g] && we_n[g]) ? mem[sram_a[g]] : {DW{1'bz}};

        always @(negedge CLK) begin
            if (!ce_n[g] && !we_n[g]) begin
                if (!lb_n[g]) mem[sram_a[g]][7:0]  <= io[7:0];
                if (!ub_n[g]) mem[sram_a[g]][15:8] <= io[15:8];
            end
        end
    end

    function automatic int rcyc(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int wcyc(input int g);
        return (g == 0) ? 1 : 2;
    endfunction

    function automatic int exp_wlat(input int g);
        return POSTED ? 1 : wcyc(g) + 2;
    endfunction

    function automatic int unsigned mkey(input int g, input logic [AW-1:0] a);
        return (32'(g) << AW) | 32'(a);
    endfunction

    task automatic ref_write(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [1:0] b);
        logic [DW-1:0] old;
        old = ref_mem.exists(mkey(g, a)) ? ref_mem[mkey(g, a)] : '0;
        if (b[0]) old[7:0]  = d[7:0];
        if (b[1]) old[15:8] = d[15:8];
        ref_mem[mkey(g, a)] = old;
    endtask

    // Issue one request and record what the pins did until the controller is idle again
    task automatic do_txn(input int g, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] b,
                          input bit keep, input bit early, output txn_res_t r);
        bit seen_low;
        int k;
        r.lat = 0; r.rd = '0; r.acc_wait = 0; r.we_low = 0; r.oe_low = 0; r.drv_cyc = 0;
        r.ack_cyc = 0; r.bad = 0; r.conflict = 0; r.gap_ok = 1'b0; r.tmo = 1'b0;
        we[g] = w; addr[g] = a; wdata[g] = d; be[g] = b; req[g] = 1'b1;
        seen_low = !busy[g];
        forever begin
            @(negedge CLK);
            r.acc_wait++;
            if (busy[g] && seen_low) break;
            if (!busy[g]) seen_low = 1'b1;
            if (r.acc_wait > 60) begin
                r.tmo = 1'b1;
                req[g] = 1'b0;
                return;
            end
        end
        k = 0;
        forever begin
            if (!busy[g]) begin
                r.gap_ok = ({ce_n[g], oe_n[g], we_n[g], lb_n[g], ub_n[g]} === 5'b11111) &&
                           (drv[g] === 1'b0) && (ack[g] === 1'b0);
                if (!keep) req[g] = 1'b0;
                break;
            end
            if (ack[g]) begin
                r.ack_cyc++;
                if (r.lat == 0) begin
                    r.lat = k + 1;
                    r.rd  = rdata[g];
                    if (!keep) req[g] = 1'b0;
                    if (early) break;
                end
            end
            if (!we_n[g]) r.we_low++;
            if (!oe_n[g]) r.oe_low++;
            if (drv[g]) r.drv_cyc++;
            if (drv[g] && !oe_n[g]) r.conflict++;
            if (sram_a[g] !== a) r.bad++;
            if (!ce_n[g] && ((lb_n[g] !== !b[0]) || (ub_n[g] !== !b[1]))) r.bad++;
            k++;
            if (k > 60) begin
                r.tmo = 1'b1;
                req[g] = 1'b0;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        for (int g = 0; g < NI; g++) begin
            checks++; if (ack[g] !== 1'b0) begin errors++; $display("FAIL rst_ack[%0d] got=%b exp=0", g, ack[g]); end
            checks++; if (busy[g] !== 1'b0) begin errors++; $display("FAIL rst_busy[%0d] got=%b exp=0", g, busy[g]); end
            checks++; if (rdata[g] !== 16'h0000) begin errors++; $display("FAIL rst_rdata[%0d] got=%h exp=0000", g, rdata[g]); end
            checks++; if (sram_a[g] !== 18'h00000) begin errors++; $display("FAIL rst_addr[%0d] got=%h exp=00000", g, sram_a[g]); end
            checks++; if ({ce_n[g], oe_n[g], we_n[g], lb_n[g], ub_n[g]} !== 5'b11111) begin errors++; $display("FAIL rst_strobes[%0d] got=%b exp=11111", g, {ce_n[g], oe_n[g], we_n[g], lb_n[g], ub_n[g]}); end
            checks++; if (drv[g] !== 1'b0) begin errors++; $display("FAIL rst_io_drive[%0d] got=%b exp=0", g, drv[g]); end
        end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        txn_res_t r;
        @(negedge CLK);
        do_txn(0, 1'b1, 18'h00005, 16'h1234, 2'b11, 1'b0, 1'b0, r);
        ref_write(0, 18'h00005, 16'h1234, 2'b11);
        checks++; if (r.tmo) begin errors++; $display("FAIL basic_wr_timeout got=%0d exp=0", r.tmo); end
        checks++; if (r.lat !== exp_wlat(0)) begin errors++; $display("FAIL basic_wr_lat got=%0d exp=%0d", r.lat, exp_wlat(0)); end
        checks++; if (r.we_low !== wcyc(0)) begin errors++; $display("FAIL basic_we_low got=%0d exp=%0d", r.we_low, wcyc(0)); end
        checks++; if (r.drv_cyc !== wcyc(0) + 2) begin errors++; $display("FAIL basic_io_drive got=%0d exp=%0d", r.drv_cyc, wcyc(0) + 2); end
        checks++; if (r.oe_low !== 0) begin errors++; $display("FAIL basic_wr_oe got=%0d exp=0", r.oe_low); end
        checks++; if (r.ack_cyc !== 1) begin errors++; $display("FAIL basic_wr_ack_len got=%0d exp=1", r.ack_cyc); end
        checks++; if (r.bad !== 0) begin errors++; $display("FAIL basic_wr_pins got=%0d exp=0", r.bad); end
        checks++; if (!r.gap_ok) begin errors++; $display("FAIL basic_wr_idle got=%0d exp=1", r.gap_ok); end
        do_txn(0, 1'b0, 18'h00005, 16'h0000, 2'b11, 1'b0, 1'b0, r);
        checks++; if (r.lat !== rcyc(0) + 1) begin errors++; $display("FAIL basic_rd_lat got=%0d exp=%0d", r.lat, rcyc(0) + 1); end
        checks++; if (r.rd !== ref_mem[mkey(0, 18'h00005)]) begin errors++; $display("FAIL basic_rd_data got=%h exp=%h", r.rd, ref_mem[mkey(0, 18'h00005)]); end
        checks++; if (r.oe_low !== rcyc(0)) begin errors++; $display("FAIL basic_rd_oe got=%0d exp=%0d", r.oe_low, rcyc(0)); end
        checks++; if (r.drv_cyc !== 0) begin errors++; $display("FAIL basic_rd_io_drive got=%0d exp=0", r.drv_cyc); end
    endtask

    task automatic test_byte_lanes();
        txn_res_t r;
        logic [DW-1:0] last_rd;
        logic [DW-1:0] d [3];
        logic [1:0]    b [3];
        d[0] = 16'hABCD; b[0] = 2'b01;
        d[1] = 16'hEF00; b[1] = 2'b10;
        d[2] = 16'h9999; b[2] = 2'b00;
        last_rd = ref_mem[mkey(0, 18'h00005)];
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            do_txn(0, 1'b1, 18'h00005, d[i], b[i], 1'b0, 1'b0, r);
            ref_write(0, 18'h00005, d[i], b[i]);
            checks++; if (r.lat !== exp_wlat(0)) begin errors++; $display("FAIL lane_wr_lat[%0d] got=%0d exp=%0d", i, r.lat, exp_wlat(0)); end
            checks++; if (r.bad !== 0) begin errors++; $display("FAIL lane_wr_pins[%0d] got=%0d exp=0", i, r.bad); end
            checks++; if (rdata[0] !== last_rd) begin errors++; $display("FAIL lane_rdata_hold[%0d] got=%h exp=%h", i, rdata[0], last_rd); end
            do_txn(0, 1'b0, 18'h00005, 16'h0000, 2'b11, 1'b0, 1'b0, r);
            last_rd = ref_mem[mkey(0, 18'h00005)];
            checks++; if (r.rd !== last_rd) begin errors++; $display("FAIL lane_rd_data[%0d] got=%h exp=%h", i, r.rd, last_rd); end
        end
    endtask

    task automatic test_long_timing();
        txn_res_t r;
        @(negedge CLK);
        do_txn(1, 1'b1, 18'h3FFFF, 16'h5A5A, 2'b11, 1'b0, 1'b0, r);
        ref_write(1, 18'h3FFFF, 16'h5A5A, 2'b11);
        checks++; if (r.lat !== exp_wlat(1)) begin errors++; $display("FAIL long_wr_lat got=%0d exp=%0d", r.lat, exp_wlat(1)); end
        checks++; if (r.we_low !== wcyc(1)) begin errors++; $display("FAIL long_we_low got=%0d exp=%0d", r.we_low, wcyc(1)); end
        checks++; if (r.drv_cyc !== wcyc(1) + 2) begin errors++; $display("FAIL long_io_drive got=%0d exp=%0d", r.drv_cyc, wcyc(1) + 2); end
        checks++; if (r.bad !== 0) begin errors++; $display("FAIL long_wr_addr_hold got=%0d exp=0", r.bad); end
        do_txn(1, 1'b0, 18'h3FFFF, 16'h0000, 2'b11, 1'b0, 1'b0, r);
        checks++; if (r.lat !== rcyc(1) + 1) begin errors++; $display("FAIL long_rd_lat got=%0d exp=%0d", r.lat, rcyc(1) + 1); end
        checks++; if (r.oe_low !== rcyc(1)) begin errors++; $display("FAIL long_rd_oe got=%0d exp=%0d", r.oe_low, rcyc(1)); end
        checks++; if (r.rd !== ref_mem[mkey(1, 18'h3FFFF)]) begin errors++; $display("FAIL long_rd_data got=%h exp=%h", r.rd, ref_mem[mkey(1, 18'h3FFFF)]); end
        checks++; if (r.bad !== 0) begin errors++; $display("FAIL long_rd_addr_hold got=%0d exp=0", r.bad); end
    endtask

    task automatic test_back_to_back();
        txn_res_t r1, r2, r3;
        logic [AW-1:0] ra, wa;
        @(negedge CLK);
        for (int g = 0; g < NI; g++) begin
            ra = 18'h00040;
            wa = 18'h00041;
            do_txn(g, 1'b1, ra, 16'hC0DE + 16'(g), 2'b11, 1'b0, 1'b0, r1);
            ref_write(g, ra, 16'hC0DE + 16'(g), 2'b11);
            do_txn(g, 1'b0, ra, 16'h0000, 2'b11, 1'b1, 1'b0, r1);
            do_txn(g, 1'b1, wa, 16'h7E57, 2'b11, 1'b0, 1'b0, r2);
            ref_write(g, wa, 16'h7E57, 2'b11);
            checks++; if (r1.rd !== ref_mem[mkey(g, ra)]) begin errors++; $display("FAIL b2b_rd_data[%0d] got=%h exp=%h", g, r1.rd, ref_mem[mkey(g, ra)]); end
            checks++; if (r1.conflict + r2.conflict !== 0) begin errors++; $display("FAIL b2b_io_contention[%0d] got=%0d exp=0", g, r1.conflict + r2.conflict); end
            checks++; if (!r1.gap_ok) begin errors++; $display("FAIL b2b_idle_gap[%0d] got=%0d exp=1", g, r1.gap_ok); end
            checks++; if (r2.acc_wait !== 1) begin errors++; $display("FAIL b2b_accept_wait[%0d] got=%0d exp=1", g, r2.acc_wait); end
            checks++; if (r2.lat !== exp_wlat(g)) begin errors++; $display("FAIL b2b_wr_lat[%0d] got=%0d exp=%0d", g, r2.lat, exp_wlat(g)); end
            do_txn(g, 1'b0, wa, 16'h0000, 2'b11, 1'b0, 1'b0, r3);
            checks++; if (r3.rd !== ref_mem[mkey(g, wa)]) begin errors++; $display("FAIL b2b_wr_readback[%0d] got=%h exp=%h", g, r3.rd, ref_mem[mkey(g, wa)]); end
        end
    endtask

    task automatic test_random();
        txn_res_t r;
        logic [AW-1:0] pool [8];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    b;
        for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
        @(negedge CLK);
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < 8; i++) begin
                d = DW'($urandom);
                do_txn(g, 1'b1, pool[i], d, 2'b11, 1'b0, 1'b0, r);
                ref_write(g, pool[i], d, 2'b11);
                checks++; if (r.lat !== exp_wlat(g)) begin errors++; $display("FAIL rnd_init_lat[%0d] got=%0d exp=%0d", g, r.lat, exp_wlat(g)); end
            end
            for (int n = 0; n < 20; n++) begin
                a = pool[$urandom_range(0, 7)];
                if ($urandom_range(0, 1) == 1) begin
                    d = DW'($urandom);
                    b = 2'($urandom);
                    do_txn(g, 1'b1, a, d, b, 1'b0, 1'b0, r);
                    ref_write(g, a, d, b);
                    checks++; if (r.lat !== exp_wlat(g)) begin errors++; $display("FAIL rnd_wr_lat[%0d] got=%0d exp=%0d", g, r.lat, exp_wlat(g)); end
                    checks++; if (r.we_low !== wcyc(g)) begin errors++; $display("FAIL rnd_we_low[%0d] got=%0d exp=%0d", g, r.we_low, wcyc(g)); end
                end else begin
                    do_txn(g, 1'b0, a, 16'h0000, 2'b11, 1'b0, 1'b0, r);
                    checks++; if (r.lat !== rcyc(g) + 1) begin errors++; $display("FAIL rnd_rd_lat[%0d] got=%0d exp=%0d", g, r.lat, rcyc(g) + 1); end
                    checks++; if (r.rd !== ref_mem[mkey(g, a)]) begin errors++; $display("FAIL rnd_rd_data[%0d] addr=%h got=%h exp=%h", g, a, r.rd, ref_mem[mkey(g, a)]); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        txn_res_t r;
        int n;
        int ack_seen;
        @(negedge CLK);
        do_txn(1, 1'b1, 18'h00100, 16'hC3C3, 2'b11, 1'b0, 1'b0, r);
        ref_write(1, 18'h00100, 16'hC3C3, 2'b11);
        we[1] = 1'b1; addr[1] = 18'h00200; wdata[1] = 16'h1111; be[1] = 2'b11; req[1] = 1'b1;
        n = 0;
        while (we_n[1] !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++; if (we_n[1] !== 1'b0) begin errors++; $display("FAIL rstw_reach_pulse got=%b exp=0", we_n[1]); end
        RESET = 1'b1;
        req[1] = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        ref_mem.delete(mkey(1, 18'h00200));
        checks++; if ({ce_n[1], oe_n[1], we_n[1], lb_n[1], ub_n[1]} !== 5'b11111) begin errors++; $display("FAIL rstw_strobes got=%b exp=11111", {ce_n[1], oe_n[1], we_n[1], lb_n[1], ub_n[1]}); end
        checks++; if (drv[1] !== 1'b0) begin errors++; $display("FAIL rstw_io_drive got=%b exp=0", drv[1]); end
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL rstw_busy got=%b exp=0", busy[1]); end
        checks++; if (rdata[1] !== 16'h0000) begin errors++; $display("FAIL rstw_rdata got=%h exp=0000", rdata[1]); end
        ack_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (ack[1] !== 1'b0) ack_seen++;
            @(negedge CLK);
        end
        checks++; if (ack_seen !== 0) begin errors++; $display("FAIL rstw_no_ack got=%0d exp=0", ack_seen); end
        do_txn(1, 1'b0, 18'h00100, 16'h0000, 2'b11, 1'b0, 1'b0, r);
        checks++; if (r.lat !== rcyc(1) + 1) begin errors++; $display("FAIL rstw_rd_lat got=%0d exp=%0d", r.lat, rcyc(1) + 1); end
        checks++; if (r.rd !== ref_mem[mkey(1, 18'h00100)]) begin errors++; $display("FAIL rstw_rd_data got=%h exp=%h", r.rd, ref_mem[mkey(1, 18'h00100)]); end
    endtask

`ifdef SRAM_ASYNC_CTRL_POSTWR_EN
    task automatic test_posted();
        txn_res_t r1, r2;
        @(negedge CLK);
        do_txn(0, 1'b1, 18'h0000A, 16'h0F0F, 2'b11, 1'b0, 1'b1, r1);
        ref_write(0, 18'h0000A, 16'h0F0F, 2'b11);
        do_txn(0, 1'b0, 18'h0000A, 16'h0000, 2'b11, 1'b0, 1'b0, r2);
        checks++; if (r1.lat !== 1) begin errors++; $display("FAIL post_wr_lat got=%0d exp=1", r1.lat); end
        checks++; if (r2.acc_wait !== wcyc(0) + 3) begin errors++; $display("FAIL post_rd_accept got=%0d exp=%0d", r2.acc_wait, wcyc(0) + 3); end
        checks++; if (r2.lat !== rcyc(0) + 1) begin errors++; $display("FAIL post_rd_lat got=%0d exp=%0d", r2.lat, rcyc(0) + 1); end
        checks++; if (r2.rd !== ref_mem[mkey(0, 18'h0000A)]) begin errors++; $display("FAIL post_rd_data got=%h exp=%h", r2.rd, ref_mem[mkey(0, 18'h0000A)]); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        RESET  = 1'b1;
        req    = '0;
        we     = '0;
        addr   = '0;
        wdata  = '0;
        be     = '0;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_long_timing();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
`ifdef SRAM_ASYNC_CTRL_POSTWR_EN
        test_posted();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
